// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divider with a pipeline stall/ready handshake.
// Define DIV_SIGNED_EN to honour signed_div (DIV). Otherwise every divide is unsigned (DIVU).
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               annul,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               div_stall
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] rem_nx, quo_nx, rem_fix, quo_fix;
    logic [WIDTH:0]   shifted, diff;

    wire accept = (state == IDLE) && start && !annul;

`ifdef DIV_SIGNED_EN
    logic dvd_neg, dvs_neg, neg_quo, neg_rem;

    always_comb begin
        dvd_neg = signed_div & dividend[WIDTH-1];
        dvs_neg = signed_div & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;
        quo_fix = neg_quo ? -quo_nx : quo_nx;
        rem_fix = neg_rem ? -rem_nx : rem_nx;
    end

    // Remainder follows the dividend sign; quotient is negated when the signs differ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept) begin
            neg_quo <= dvd_neg ^ dvs_neg;
            neg_rem <= dvd_neg;
        end
    end
`else
    logic unused_signed_div;
    assign unused_signed_div = signed_div;

    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        quo_fix = quo_nx;
        rem_fix = rem_nx;
    end
`endif

    // One restoring step: the quotient register doubles as the dividend shift register.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (diff[WIDTH]) begin
            rem_nx = shifted[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_nx = diff[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            result <= '0;
            ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_q <= '0;
                        quo_q <= dvd_mag;
                        dvs_q <= dvs_mag;
                        cnt   <= '0;
                        state <= (divisor == '0) ? BYZERO : ON;
                    end
                end
                ON: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            result <= {rem_fix, quo_fix};
                            ready  <= 1'b1;
                            state  <= END;
                        end
                    end
                end
                BYZERO: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        result <= '0;
                        ready  <= 1'b1;
                        state  <= END;
                    end
                end
                END: begin
                    if (!start) begin
                        result <= '0;
                        ready  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        div_stall = 1'b0;
        case (state)
            IDLE:       div_stall = start & ~annul;
            ON, BYZERO: div_stall = 1'b1;
            default:    div_stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl (WIDTH=32): vector table plus annul/reset corner sequences.
// Expected values for signed_div=1 vectors depend on whether DIV_SIGNED_EN is defined.
module tb_div_ctrl;
    localparam int W = 32;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic           annul;
    logic           signed_div;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic [2*W-1:0] result;
    logic           ready;
    logic           div_stall;

    int n_tests = 0;
    int n_fail  = 0;

    div_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .annul      (annul),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .result     (result),
        .ready      (ready),
        .div_stall  (div_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sd;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with start already high on an IDLE DUT (acceptance cycle).
    task automatic wait_result(input string name, input int lat,
                               input logic [31:0] q, input logic [31:0] r);
        int k = 0;
        int stalls = 0;
        #1;
        if (div_stall) stalls++;
        while (!ready && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (div_stall) stalls++;
        end
        check({name, " stall_cycles"}, 64'(stalls), 64'(lat));
        check({name, " ready_cycle"}, 64'(k), 64'(lat));
        check({name, " result"}, result, {r, q});
        annul = 1'b1;
        @(negedge clk);
        check({name, " end_hold"}, {62'(0), ready, div_stall}, 64'b10);
        check({name, " end_result_hold"}, result, {r, q});
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check({name, " cleared"}, {ready, div_stall, result[61:0]}, 64'd0);
        check({name, " cleared_hi"}, 64'(result[63:62]), 64'd0);
    endtask

    task automatic apply(input logic sd, input logic [31:0] dvd, input logic [31:0] dvs);
        signed_div = sd;
        dividend   = dvd;
        divisor    = dvs;
        start      = 1'b1;
    endtask

    initial begin
        int ready_seen;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1]  = '{1'b0, 32'h0000_1234,  32'd0,          32'd0,          32'd0,          2};
        vecs[2]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
        vecs[3]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          33};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33};
        vecs[5]  = '{1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          33};
        vecs[6]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33};
        vecs[7]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[8]  = '{1'b1, 32'd0,          32'd0,          32'd0,          32'd0,          2};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'd0,          32'd0,          2};
`ifdef DIV_SIGNED_EN
        vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
        vecs[12] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vecs[13] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
`else
        vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
        vecs[12] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'd0,          32'd7,          33};
        vecs[13] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FF9C,  33};
`endif

        reset_n    = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {ready, div_stall, result[61:0]}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_no_start", {62'(0), ready, div_stall}, 64'd0);

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].sd, vecs[i].dvd, vecs[i].dvs);
            wait_result($sformatf("vec%0d", i), vecs[i].lat, vecs[i].q, vecs[i].r);
        end

        // Annul at ON cycle 10, then a fresh divide with start still held.
        apply(1'b0, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        check("annul_on_idle", {62'(0), ready, div_stall}, 64'd0);
        annul = 1'b0;
        apply(1'b0, 32'd1000, 32'd33);
        wait_result("after_annul_on", 33, 32'd30, 32'd10);

        // Annul in BYZERO: no ready pulse may ever follow.
        apply(1'b0, 32'h1234, 32'd0);
        @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        check("annul_byzero_idle", {62'(0), ready, div_stall}, 64'd0);
        start = 1'b0;
        annul = 1'b0;
        ready_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready) ready_seen++;
        end
        check("annul_byzero_no_ready", 64'(ready_seen), 64'd0);

        // Reset mid-divide at ON cycle 5; start held across release starts a new op.
        apply(1'b0, 32'd100, 32'd7);
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset_mid_div", {ready, result[62:0]}, 64'd0);
        check("reset_mid_stall", 64'(div_stall), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        apply(1'b0, 32'd100, 32'd7);
        wait_result("after_reset", 33, 32'd14, 32'd2);

        // Asynchronous reset while a result is being held in END.
        apply(1'b0, 32'd77, 32'd10);
        repeat (40) begin
            if (!ready) @(negedge clk);
        end
        check("end_before_reset", {ready, result[62:0]}, {1'b1, 31'd7, 32'd7});
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_end", {ready, result[62:0]}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {62'(0), ready, div_stall}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width in bits.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  EX-stage divide request, held high until result consumed.
REQ-005 The block SHALL have port annul  input  1  flush/cancel of the in-flight divide.
REQ-006 The block SHALL have port signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-007 The block SHALL have port dividend  input  WIDTH  numerator, sampled at acceptance.
REQ-008 The block SHALL have port divisor  input  WIDTH  denominator, sampled at acceptance.
REQ-009 The block SHALL have port result  output  2*WIDTH  {remainder, quotient}, valid while ready=1.
REQ-010 The block SHALL have port ready  output  1  result valid.
REQ-011 The block SHALL have port div_stall  output  1  stall request to the pipeline controller's EX stall input.

Function
REQ-012 The block SHALL implement FSM states IDLE, BYZERO, ON, END.
REQ-013 In IDLE with start=1, annul=0: acceptance cycle; latch operands; next state BYZERO if divisor==0, else ON with cnt=0.
REQ-014 In IDLE with start=0 or annul=1: remain IDLE; no operand latch.
REQ-015 In ON: one restoring shift-subtract step per cycle, cnt incremented; exactly WIDTH cycles in ON.
REQ-016 On the step with cnt==WIDTH-1: apply sign correction, register result, next state END.
REQ-017 In BYZERO: result = 0 (quotient and remainder); next state END after one cycle.
REQ-018 In ON or BYZERO with annul=1: next state IDLE; partial result discarded; ready never asserts for that op.
REQ-019 In END: ready=1, result held stable; stay in END while start=1; go IDLE (ready=0, result cleared to 0) when start=0.
REQ-020 div_stall SHALL be combinational: 1 when (IDLE and start and !annul) or ON or BYZERO; 0 in END and otherwise.
REQ-021 Latency: nonzero divisor -> div_stall high WIDTH+1 cycles, ready high in cycle WIDTH+1 after acceptance; divisor 0 -> 2 stall cycles, ready in cycle 2.
REQ-022 Signed mode: operate on magnitudes; quotient negated if operand signs differ; remainder takes dividend sign.
REQ-023 Most-negative / -1 (signed) SHALL yield quotient 0x8000_0000 (WIDTH=32), remainder 0, no exception.
REQ-024 start asserted in END SHALL NOT restart a new divide; a new op requires passing through IDLE.
REQ-025 annul in END SHALL be ignored; exit only via start=0.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state IDLE, cnt=0, result=0, ready=0; div_stall then follows REQ-020.
REQ-027 Reset mid-divide SHALL abandon the operation; after release no ready pulse for that op.

Configuration
REQ-028 Macro DIV_SIGNED_EN defined: signed_div honoured per REQ-022/REQ-023.
REQ-029 Macro DIV_SIGNED_EN undefined: signed_div ignored, all divides unsigned, sign-correction logic absent; port remains present.

Verification
REQ-030 Unsigned 100/7 (WIDTH=32) -> div_stall 33 cycles, then ready=1, quotient 14, remainder 2.
REQ-031 DIV_SIGNED_EN, signed -7/2 -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF; signed 0x8000_0000/0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0.
REQ-032 Divisor 0, dividend 0x1234 -> div_stall 2 cycles, ready=1, result 0.
REQ-033 annul at ON cycle 10 -> IDLE next cycle, div_stall=0, ready stays 0; fresh start completes normally.
REQ-034 reset_n low at ON cycle 5 -> immediate IDLE, result 0, ready 0; start held after release -> new divide completes in 33 cycles.
REQ-035 DIV_SIGNED_EN undefined, signed_div=1, 0xFFFF_FFF9/2 -> quotient 0x7FFF_FFFC, remainder 1.
